// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, funct3 codes,
// response causes and the request fault / byte-enable helpers.
package lsu_pkg;

    // FSM state encoding
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DATA   = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    // RV32 funct3 codes for loads and stores
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        CAUSE_OK       = 2'd0,
        CAUSE_MISALIGN = 2'd1,
        CAUSE_FUNCT3   = 2'd2,
        CAUSE_RANGE    = 2'd3
    } cause_t;

    // Classify a request; earlier checks take priority over later ones.
    function automatic cause_t check_request(input logic        is_store,
                                             input logic [2:0]  funct3,
                                             input logic [31:0] addr,
                                             input logic [31:0] limit);
        logic bad_f3;
        logic half;
        logic word;
        if (is_store) begin
            bad_f3 = (funct3 > F3_W);
        end else begin
            bad_f3 = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
        end
        half = (funct3[1:0] == 2'b01);
        word = (funct3[1:0] == 2'b10);
        if (bad_f3) begin
            return CAUSE_FUNCT3;
        end else if ((half && addr[0]) || (word && (addr[1:0] != 2'b00))) begin
            return CAUSE_MISALIGN;
        end else if (addr >= limit) begin
            return CAUSE_RANGE;
        end else begin
            return CAUSE_OK;
        end
    endfunction

    // Store byte-lane enables for an access size at a byte offset.
    function automatic logic [3:0] byte_enable(input logic [2:0] funct3,
                                               input logic [1:0] offset);
        case (funct3[1:0])
            2'b00:   return 4'b0001 << offset;
            2'b01:   return 4'b0011 << offset;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Shifts a raw memory word down to the addressed byte lane and applies the
// sign or zero extension selected by the load funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted_s;

    // Lane shift followed by width-dependent extension
    always_comb begin
        shifted_s = raw >> {offset, 3'b000};
        case (funct3)
            F3_B:    data = {{24{shifted_s[7]}}, shifted_s[7:0]};
            F3_BU:   data = {24'h000000, shifted_s[7:0]};
            F3_H:    data = {{16{shifted_s[15]}}, shifted_s[15:0]};
            F3_HU:   data = {16'h0000, shifted_s[15:0]};
            default: data = shifted_s;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load or store in flight, checked for faults on
// accept, driven to a read-latency-one SRAM, with a registered response.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_SIZE       = 16,
    parameter int MEM_ADDR_WIDTH = $clog2(MEM_SIZE)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      reqValid,
    output logic                      reqReady,
    input  logic                      reqStore,
    input  logic [2:0]                reqFunct3,
    input  logic [31:0]               reqAddr,
    input  logic [31:0]               reqWData,
    output logic                      respValid,
    input  logic                      respReady,
    output logic [31:0]               respData,
    output logic                      respErr,
    output logic [1:0]                respCause,
    output logic                      memEn,
    output logic                      memR,
    output logic                      memW,
    output logic [MEM_ADDR_WIDTH-1:0] memRAddr,
    output logic [MEM_ADDR_WIDTH-1:0] memWAddr,
    output logic [3:0]                memByteEn,
    output logic [31:0]               memIn,
    input  logic [31:0]               memOut
);

    localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_SIZE);

    logic [1:0]                state_r;
    logic                      store_r;
    logic [2:0]                funct3_r;
    logic [1:0]                offset_r;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_r;
    logic [31:0]               mem_in_r;
    logic [3:0]                be_r;
    logic [31:0]               resp_data_r;
    logic                      resp_err_r;
    cause_t                    resp_cause_r;
    cause_t                    req_cause_s;
    logic [31:0]               aligned_s;
    logic                      mem_en_s;

    lsu_load_align u_align (
        .raw    (memOut),
        .offset (offset_r),
        .funct3 (funct3_r),
        .data   (aligned_s)
    );

    // Fault classification of the request currently offered
    always_comb begin
        req_cause_s = check_request(reqStore, reqFunct3, reqAddr, ADDR_LIMIT);
    end

    // Request latch, FSM sequencing and response register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            store_r      <= 1'b0;
            funct3_r     <= 3'd0;
            offset_r     <= 2'd0;
            mem_addr_r   <= '0;
            mem_in_r     <= 32'h0000_0000;
            be_r         <= 4'b0000;
            resp_data_r  <= 32'h0000_0000;
            resp_err_r   <= 1'b0;
            resp_cause_r <= CAUSE_OK;
        end else begin
            case (state_r)
                IDLE: begin
                    if (reqValid) begin
                        store_r     <= reqStore;
                        funct3_r    <= reqFunct3;
                        offset_r    <= reqAddr[1:0];
                        mem_addr_r  <= reqAddr[MEM_ADDR_WIDTH+1:2];
                        mem_in_r    <= reqWData << {reqAddr[1:0], 3'b000};
                        be_r        <= byte_enable(reqFunct3, reqAddr[1:0]);
                        resp_data_r <= 32'h0000_0000;
                        resp_cause_r <= req_cause_s;
                        if (req_cause_s != CAUSE_OK) begin
                            resp_err_r <= 1'b1;
                            state_r    <= RESP;
                        end else begin
                            resp_err_r <= 1'b0;
                            state_r    <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    state_r <= store_r ? RESP : DATA;
                end
                DATA: begin
                    resp_data_r <= aligned_s;
                    state_r     <= RESP;
                end
                RESP: begin
                    if (respReady) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Memory strobes are live only in ACCESS and are killed by reset at once
    always_comb begin
        mem_en_s = (state_r == ACCESS) && !rst;
    end

    assign memEn     = mem_en_s;
    assign memR      = mem_en_s && !store_r;
    assign memW      = mem_en_s && store_r;
    assign memByteEn = (mem_en_s && store_r) ? be_r : 4'b0000;
    assign memRAddr  = mem_addr_r;
    assign memWAddr  = mem_addr_r;
    assign memIn     = mem_in_r;
    assign reqReady  = (state_r == IDLE);
    assign respValid = (state_r == RESP);
    assign respData  = resp_data_r;
    assign respErr   = resp_err_r;
    assign respCause = resp_cause_r;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the core's data-memory port: accepts one RV32 load or store per handshake from the microcoded control unit. It converts the byte address and funct3 into a word address, byte enables and lane-shifted write data for `dataMem`, which runs with FALL_THROUGH=0, so read data returns one cycle after issue. It then aligns and sign- or zero-extends load data and returns a response with an error cause. It sits between the core datapath and the synchronous data SRAM.

## Interface
- `MEM_SIZE`, 16: number of 32-bit words in the attached memory.
- `MEM_ADDR_WIDTH`, $clog2(MEM_SIZE): word-address width on the memory side.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset; **one clock; reset is synchronous and active-high**.
- `reqValid`  in  1  request present.
- `reqReady`  out  1  high only in IDLE.
- `reqStore`  in  1  1 = store, 0 = load.
- `reqFunct3`  in  3  RV32 funct3: LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2.
- `reqAddr`  in  32  byte address.
- `reqWData`  in  32  store data, right-justified.
- `respValid`  out  1  response present; held until `respReady`.
- `respReady`  in  1  consumer accepts the response.
- `respData`  out  32  extended load data; 0 for stores and errors.
- `respErr`  out  1  request faulted; the memory was not touched.
- `respCause`  out  2  0 ok, 1 misaligned, 2 illegal funct3, 3 out of range.
- `memEn`, `memR`, `memW`  out  1 each  memory controls.
- `memRAddr`, `memWAddr`  out  MEM_ADDR_WIDTH  word address, equal to `reqAddr[MEM_ADDR_WIDTH+1:2]`.
- `memByteEn`  out  4  byte lane enables.
- `memIn`  out  32  lane-shifted write data.
- `memOut`  in  32  registered memory read data.

## Operation
- FSM states and transitions:
  - IDLE: on `reqValid && reqReady`, latch the request and check it. A faulted request goes to RESP; otherwise go to ACCESS.
  - ACCESS: drive the memory. A load goes to DATA; a store goes to RESP.
  - DATA: capture `memOut`, align and extend it into the response register, go to RESP.
  - RESP: `respValid`=1; on `respReady` go to IDLE.
- Fault checks, in priority order:
  - Illegal funct3 (cause 2): a load with funct3 in {3,6,7}, or a store with funct3 ≥ 3.
  - Misaligned (cause 1): a halfword access with addr[0]=1, or a word access with addr[1:0]≠0.
  - Out of range (cause 3): `reqAddr` ≥ 4·MEM_SIZE.
  - A faulted request never asserts `memEn`.
- Byte enables and write data for stores:
  - SB: `4'b0001 << addr[1:0]`.
  - SH: `4'b0011 << addr[1:0]`.
  - SW: `4'b1111`.
  - `memIn = reqWData << (8·addr[1:0])`; lanes with the enable clear are don't-care.
- Load alignment and extension:
  - Shift: `sh = memOut >> (8·addr[1:0])`.
  - LB: sign-extend `sh[7:0]`; LBU: zero-extend it.
  - LH: sign-extend `sh[15:0]`; LHU: zero-extend it.
  - LW: `sh` unchanged.
- Memory controls:
  - `memEn` = (state==ACCESS) && !rst.
  - `memR` = load, `memW` = store, both gated the same way as `memEn`.
  - Outside ACCESS, `memEn`/`memR`/`memW`/`memByteEn` are 0; addresses and `memIn` hold their latched values.
  - Loads drive `memByteEn`=0.

## Timing
- Request accepted at edge 0:
  - Store: ACCESS in cycle 1, write committed at edge 2, `respValid` from cycle 2.
  - Load: ACCESS in cycle 1, `memOut` valid in cycle 2 (DATA), `respValid` from cycle 3.
  - Fault: `respValid` from cycle 1.
- One request is in flight at most. `reqReady`=0 from the accept edge until RESP completes, so back-to-back throughput is one store per 3 cycles or one load per 4 cycles when `respReady` stays high.
- `respData`, `respErr` and `respCause` are registered and stable for as long as `respValid` is high.
- Reset values: state IDLE, `reqReady`=1, `respValid`=0, `respData`=0, `respErr`=0, `respCause`=0, `memEn`=`memR`=`memW`=0, `memByteEn`=0, addresses and `memIn` 0.
- Reset mid-operation: `rst` high in ACCESS suppresses `memEn` in that cycle, so no write lands. An in-flight response is dropped and is never delivered.

## Structure
- `lsu_pkg`:
  - state enum {IDLE, ACCESS, DATA, RESP}.
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - cause enum {CAUSE_OK, CAUSE_MISALIGN, CAUSE_FUNCT3, CAUSE_RANGE}.
- One sub-module, `lsu_load_align`: combinational shift and extend of the 32-bit load data by addr[1:0] and funct3, reused by the bench reference model.

## Test plan
- SW addr 0x8 data 0xDEADBEEF, then LW 0x8:
  - The write cycle shows memWAddr=2 and byteEn=1111.
  - The load returns 0xDEADBEEF with respCause=0; respValid is high 3 cycles after accept.
- Over word 0x11223380, byte and halfword loads return:
  - LB 0x4 → 0xFFFFFF80; LBU 0x4 → 0x00000080.
  - LH 0x6 → 0x00001122; LHU 0x4 → 0x00003380.
- SB 0x5 data 0x000000AB → memByteEn=0010, memIn[15:8]=0xAB; a following LW 0x4 returns 0x1122AB80.
- Faults, none of which asserts memEn:
  - LW 0x2 → respErr=1, cause 1.
  - Load with funct3=3 → cause 2.
  - SW 0x40 with MEM_SIZE=16 → cause 3.
- Hold respReady=0 for 5 cycles → respValid and respData stay stable; reqReady stays 0 and a new reqValid is ignored.
- Assert rst during ACCESS of SW 0x0 data 0x12345678 → memEn=0 that cycle, the word keeps its old value, and the next cycle shows the IDLE reset values.
